// File: rtl/piano_pkg.sv
// Shared constants and types for the piano audio path: note codes, octave-4
// half-period table and the envelope state encoding.
package piano_pkg;

  localparam int HP_W = 21;

  localparam logic [2:0] OCT_REF = 3'd4;

  localparam logic [2:0] NOTE_C = 3'd1;
  localparam logic [2:0] NOTE_D = 3'd2;
  localparam logic [2:0] NOTE_E = 3'd3;
  localparam logic [2:0] NOTE_F = 3'd4;
  localparam logic [2:0] NOTE_G = 3'd5;
  localparam logic [2:0] NOTE_A = 3'd6;
  localparam logic [2:0] NOTE_B = 3'd7;

  // Octave-4 half-periods in 100 MHz cycles, ordered C..B.
  localparam logic [HP_W-1:0] HALF_PERIOD_OCT4 [7] = '{
    21'd191113, 21'd170265, 21'd151686, 21'd143172,
    21'd127551, 21'd113636, 21'd101239
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_e;

endpackage

// File: rtl/tone_period_lut.sv
// Combinational (octave, note) -> half-period lookup. Octave 4 comes from the
// table; other octaves shift by one bit per octave. Silence maps to 0.
module tone_period_lut
  import piano_pkg::*;
(
  input  logic [2:0]      octave,
  input  logic [2:0]      note,
  output logic [HP_W-1:0] half_period
);

  logic [HP_W-1:0] base;

  always_comb begin
    base = '0;
    case (note)
      NOTE_C:  base = HALF_PERIOD_OCT4[0];
      NOTE_D:  base = HALF_PERIOD_OCT4[1];
      NOTE_E:  base = HALF_PERIOD_OCT4[2];
      NOTE_F:  base = HALF_PERIOD_OCT4[3];
      NOTE_G:  base = HALF_PERIOD_OCT4[4];
      NOTE_A:  base = HALF_PERIOD_OCT4[5];
      NOTE_B:  base = HALF_PERIOD_OCT4[6];
      default: base = '0;
    endcase
  end

  // Octave 1 C is the largest result (1,528,904) and still fits in 21 bits.
  always_comb begin
    half_period = '0;
    if (octave != 3'd0 && note != 3'd0) begin
      if (octave > OCT_REF) half_period = base >> (octave - OCT_REF);
      else                  half_period = base << (OCT_REF - octave);
    end
  end

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone generator with linear attack/release envelope and PWM
// output for the PmodAMP2. Debug outputs expose the envelope and tone state.
module tone_synth
  import piano_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int ENV_STEP_CYCLES = 39062,
  parameter int PWM_BITS        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          octave,
  input  logic [2:0]          note,
  output logic                AIN,
  output logic                GAIN,
  output logic                NC,
  output logic                ACTIVE,
  output logic [1:0]          dbg_state,
  output logic [PWM_BITS-1:0] dbg_volume,
  output logic                dbg_phase,
  output logic [HP_W-1:0]     dbg_tone_cnt
);

  localparam int PRESC_W = (ENV_STEP_CYCLES > 1) ? $clog2(ENV_STEP_CYCLES) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(ENV_STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] VOL_MAX    = {PWM_BITS{1'b1}};

  // The lookup constants assume the 100 MHz board clock.
  if (CLK_HZ <= 0) begin : g_clk_check
    $error("tone_synth: CLK_HZ must be positive");
  end

  env_state_e          state_q, state_d;
  logic [2:0]          req_oct_q, req_oct_d;
  logic [2:0]          req_note_q, req_note_d;
  logic [PWM_BITS-1:0] volume_q, volume_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [HP_W-1:0]     cnt_q, cnt_d;
  logic [HP_W-1:0]     period_q, period_d;
  logic                phase_q, phase_d;
  logic [PWM_BITS-1:0] carrier_q, carrier_d;
  logic                ain_q, ain_d;

  logic            req_valid;
  logic            step;
  logic [HP_W-1:0] lut_period;
  logic [HP_W-1:0] reload_period;

  assign req_oct_d  = octave;
  assign req_note_d = note;
  assign req_valid  = (req_oct_q != 3'd0) && (req_note_q != 3'd0);

  tone_period_lut u_lut (
    .octave      (req_oct_q),
    .note        (req_note_q),
    .half_period (lut_period)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Silence wins over reaching full scale; a valid request wins over reaching zero.
  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ATTACK;
      ATTACK: begin
        if (!req_valid)               state_d = RELEASE;
        else if (volume_q == VOL_MAX) state_d = SUSTAIN;
      end
      SUSTAIN: if (!req_valid) state_d = RELEASE;
      RELEASE: begin
        if (req_valid)            state_d = ATTACK;
        else if (volume_q == '0)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : envelope
    step    = (presc_q == PRESC_LAST);
    presc_d = step ? '0 : presc_q + 1'b1;
    if (state_d != state_q || state_q == IDLE) presc_d = '0;
    volume_d = volume_q;
    case (state_q)
      IDLE:    volume_d = '0;
      ATTACK:  if (step && volume_q != VOL_MAX) volume_d = volume_q + 1'b1;
      SUSTAIN: volume_d = VOL_MAX;
      RELEASE: if (step && volume_q != '0) volume_d = volume_q - 1'b1;
      default: volume_d = '0;
    endcase
  end

  // period_q remembers the last sounding pitch so RELEASE keeps its tone
  // after the request has gone silent.
  always_comb begin : tone
    cnt_d         = cnt_q;
    period_d      = period_q;
    phase_d       = phase_q;
    reload_period = req_valid ? lut_period : period_q;
    if (state_q == IDLE) begin
      phase_d = 1'b0;
      if (req_valid) begin
        cnt_d    = lut_period;
        period_d = lut_period;
      end
    end else if (cnt_q <= 1) begin
      cnt_d    = reload_period;
      period_d = reload_period;
      phase_d  = ~phase_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin : pwm
    carrier_d = carrier_q + 1'b1;
    ain_d     = phase_q & (carrier_q < volume_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_oct_q  <= '0;
      req_note_q <= '0;
      volume_q   <= '0;
      presc_q    <= '0;
      cnt_q      <= '0;
      period_q   <= '0;
      phase_q    <= 1'b0;
      carrier_q  <= '0;
      ain_q      <= 1'b0;
    end else begin
      req_oct_q  <= req_oct_d;
      req_note_q <= req_note_d;
      volume_q   <= volume_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      phase_q    <= phase_d;
      carrier_q  <= carrier_d;
      ain_q      <= ain_d;
    end
  end

  always_comb begin : outputs
    ACTIVE       = (state_q != IDLE);
    AIN          = ain_q;
    GAIN         = 1'b0;
    NC           = 1'b0;
    dbg_state    = state_q;
    dbg_volume   = volume_q;
    dbg_phase    = phase_q;
    dbg_tone_cnt = cnt_q;
  end

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth with a 4-cycle envelope step, plus a
// standalone check of the half-period lookup.
module tb_tone_synth;
  import piano_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [2:0]  octave;
  logic [2:0]  note;
  logic        AIN, GAIN, NC, ACTIVE;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_volume;
  logic        dbg_phase;
  logic [20:0] dbg_tone_cnt;

  logic [2:0]  lut_oct;
  logic [2:0]  lut_note;
  logic [20:0] lut_hp;

  int n_checks;
  int n_fail;

  tone_synth #(.CLK_HZ(100_000_000), .ENV_STEP_CYCLES(4), .PWM_BITS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .octave       (octave),
    .note         (note),
    .AIN          (AIN),
    .GAIN         (GAIN),
    .NC           (NC),
    .ACTIVE       (ACTIVE),
    .dbg_state    (dbg_state),
    .dbg_volume   (dbg_volume),
    .dbg_phase    (dbg_phase),
    .dbg_tone_cnt (dbg_tone_cnt)
  );

  tone_period_lut u_ref_lut (
    .octave      (lut_oct),
    .note        (lut_note),
    .half_period (lut_hp)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [2:0] n);
    octave = o;
    note   = n;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(3'd0, 3'd0);
    tick(3);
    #3 rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    int glitches;
    rst_n = 1'b0;
    drive(3'd0, 3'd0);
    tick(1);
    n_checks++; if ({AIN, ACTIVE, GAIN, NC} !== 4'b0000) begin n_fail++; $display("FAIL reset_outputs: got %b want 0000", {AIN, ACTIVE, GAIN, NC}); end
    n_checks++; if (dbg_state !== IDLE || dbg_volume !== 8'd0 || dbg_phase !== 1'b0 || dbg_tone_cnt !== 21'd0) begin n_fail++; $display("FAIL reset_state: got st=%0d vol=%0d ph=%0d cnt=%0d want 0 0 0 0", dbg_state, dbg_volume, dbg_phase, dbg_tone_cnt); end
    tick(2);
    #3 rst_n = 1'b1;
    glitches = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if ({AIN, ACTIVE, GAIN, NC} !== 4'b0000 || dbg_state !== IDLE) glitches++;
    end
    n_checks++; if (glitches !== 0) begin n_fail++; $display("FAIL idle_after_release: got %0d nonzero cycles want 0", glitches); end
  endtask

  task automatic test_lut();
    logic [2:0]  o_v [10];
    logic [2:0]  n_v [10];
    logic [20:0] e_v [10];
    o_v = '{3'd4, 3'd4, 3'd5, 3'd7, 3'd7, 3'd1, 3'd3, 3'd6, 3'd2, 3'd0};
    n_v = '{NOTE_C, NOTE_A, NOTE_C, NOTE_B, NOTE_A, NOTE_C, NOTE_E, NOTE_G, NOTE_D, NOTE_C};
    e_v = '{21'd191113, 21'd113636, 21'd95556, 21'd12654, 21'd14204,
            21'd1528904, 21'd303372, 21'd31887, 21'd681060, 21'd0};
    for (int i = 0; i < 10; i++) begin
      lut_oct  = o_v[i];
      lut_note = n_v[i];
      #1;
      n_checks++; if (lut_hp !== e_v[i]) begin n_fail++; $display("FAIL lut_oct%0d_note%0d: got %0d want %0d", o_v[i], n_v[i], lut_hp, e_v[i]); end
    end
  endtask

  task automatic test_attack_legato();
    drive(3'd4, NOTE_A);
    tick(1);
    n_checks++; if (ACTIVE !== 1'b0) begin n_fail++; $display("FAIL attack_not_early: got %0b want 0", ACTIVE); end
    tick(1);
    n_checks++; if (ACTIVE !== 1'b1 || dbg_state !== ATTACK) begin n_fail++; $display("FAIL attack_entry: got act=%0b st=%0d want 1 %0d", ACTIVE, dbg_state, ATTACK); end
    n_checks++; if (dbg_tone_cnt !== 21'd113636 || dbg_phase !== 1'b0 || dbg_volume !== 8'd0) begin n_fail++; $display("FAIL attack_load: got cnt=%0d ph=%0d vol=%0d want 113636 0 0", dbg_tone_cnt, dbg_phase, dbg_volume); end
    tick(3);
    n_checks++; if (dbg_volume !== 8'd0) begin n_fail++; $display("FAIL attack_before_step: got %0d want 0", dbg_volume); end
    tick(1);
    n_checks++; if (dbg_volume !== 8'd1) begin n_fail++; $display("FAIL attack_first_step: got %0d want 1", dbg_volume); end
    tick(1015);
    n_checks++; if (dbg_volume !== 8'd254 || dbg_state !== ATTACK) begin n_fail++; $display("FAIL attack_254: got vol=%0d st=%0d want 254 %0d", dbg_volume, dbg_state, ATTACK); end
    tick(1);
    n_checks++; if (dbg_volume !== 8'd255 || dbg_state !== ATTACK) begin n_fail++; $display("FAIL attack_255: got vol=%0d st=%0d want 255 %0d", dbg_volume, dbg_state, ATTACK); end
    tick(1);
    n_checks++; if (dbg_state !== SUSTAIN || dbg_tone_cnt !== 21'd112615) begin n_fail++; $display("FAIL sustain_entry: got st=%0d cnt=%0d want %0d 112615", dbg_state, dbg_tone_cnt, SUSTAIN); end
    // legato to (5, C): counter keeps running, no reload
    drive(3'd5, NOTE_C);
    tick(2);
    n_checks++; if (dbg_tone_cnt !== 21'd112613 || dbg_state !== SUSTAIN || dbg_volume !== 8'd255) begin n_fail++; $display("FAIL legato_sustain: got cnt=%0d st=%0d vol=%0d want 112613 %0d 255", dbg_tone_cnt, dbg_state, dbg_volume, SUSTAIN); end
  endtask

  task automatic test_release_reattack();
    int highs;
    drive(3'd0, NOTE_A);
    tick(2);
    n_checks++; if (dbg_state !== RELEASE || dbg_volume !== 8'd255) begin n_fail++; $display("FAIL release_entry: got st=%0d vol=%0d want %0d 255", dbg_state, dbg_volume, RELEASE); end
    tick(620);
    n_checks++; if (dbg_state !== RELEASE || dbg_volume !== 8'd100) begin n_fail++; $display("FAIL release_100: got st=%0d vol=%0d want %0d 100", dbg_state, dbg_volume, RELEASE); end
    drive(3'd3, NOTE_E);
    tick(1);
    n_checks++; if (dbg_state !== RELEASE) begin n_fail++; $display("FAIL reattack_latency: got %0d want %0d", dbg_state, RELEASE); end
    tick(1);
    n_checks++; if (dbg_state !== ATTACK || dbg_volume !== 8'd100) begin n_fail++; $display("FAIL reattack_entry: got st=%0d vol=%0d want %0d 100", dbg_state, dbg_volume, ATTACK); end
    tick(3);
    n_checks++; if (dbg_volume !== 8'd100) begin n_fail++; $display("FAIL reattack_hold: got %0d want 100", dbg_volume); end
    tick(1);
    n_checks++; if (dbg_volume !== 8'd101) begin n_fail++; $display("FAIL reattack_step: got %0d want 101", dbg_volume); end
    drive(3'd0, 3'd0);
    tick(2);
    n_checks++; if (dbg_state !== RELEASE || dbg_volume !== 8'd101) begin n_fail++; $display("FAIL release2_entry: got st=%0d vol=%0d want %0d 101", dbg_state, dbg_volume, RELEASE); end
    tick(403);
    n_checks++; if (dbg_volume !== 8'd1 || ACTIVE !== 1'b1) begin n_fail++; $display("FAIL release2_1: got vol=%0d act=%0b want 1 1", dbg_volume, ACTIVE); end
    tick(1);
    n_checks++; if (dbg_volume !== 8'd0 || dbg_state !== RELEASE || ACTIVE !== 1'b1) begin n_fail++; $display("FAIL release2_zero: got vol=%0d st=%0d act=%0b want 0 %0d 1", dbg_volume, dbg_state, ACTIVE, RELEASE); end
    tick(1);
    n_checks++; if (dbg_state !== IDLE || ACTIVE !== 1'b0) begin n_fail++; $display("FAIL release2_idle: got st=%0d act=%0b want %0d 0", dbg_state, ACTIVE, IDLE); end
    highs = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (AIN !== 1'b0 || ACTIVE !== 1'b0) highs++;
    end
    n_checks++; if (highs !== 0) begin n_fail++; $display("FAIL silent_after_release: got %0d active cycles want 0", highs); end
  endtask

  task automatic test_simultaneous();
    drive(3'd4, NOTE_A);
    tick(2);
    n_checks++; if (dbg_tone_cnt !== 21'd113636 || dbg_state !== ATTACK) begin n_fail++; $display("FAIL sim_load: got cnt=%0d st=%0d want 113636 %0d", dbg_tone_cnt, dbg_state, ATTACK); end
    tick(1019);
    drive(3'd0, 3'd0);
    tick(1);
    n_checks++; if (dbg_state !== ATTACK || dbg_volume !== 8'd255) begin n_fail++; $display("FAIL sim_top: got st=%0d vol=%0d want %0d 255", dbg_state, dbg_volume, ATTACK); end
    tick(1);
    n_checks++; if (dbg_state !== RELEASE || dbg_volume !== 8'd255) begin n_fail++; $display("FAIL sim_top_silence: got st=%0d vol=%0d want %0d 255", dbg_state, dbg_volume, RELEASE); end
    tick(1019);
    drive(3'd4, NOTE_A);
    tick(1);
    n_checks++; if (dbg_state !== RELEASE || dbg_volume !== 8'd0) begin n_fail++; $display("FAIL sim_bottom: got st=%0d vol=%0d want %0d 0", dbg_state, dbg_volume, RELEASE); end
    tick(1);
    n_checks++; if (dbg_state !== ATTACK || dbg_volume !== 8'd0 || ACTIVE !== 1'b1) begin n_fail++; $display("FAIL sim_bottom_valid: got st=%0d vol=%0d act=%0b want %0d 0 1", dbg_state, dbg_volume, ACTIVE, ATTACK); end
    n_checks++; if (dbg_tone_cnt !== 21'd111594) begin n_fail++; $display("FAIL sim_no_reload: got %0d want 111594", dbg_tone_cnt); end
  endtask

  task automatic test_octave1();
    apply_reset();
    drive(3'd1, NOTE_C);
    tick(2);
    n_checks++; if (dbg_tone_cnt !== 21'd1528904 || ACTIVE !== 1'b1) begin n_fail++; $display("FAIL oct1_load: got cnt=%0d act=%0b want 1528904 1", dbg_tone_cnt, ACTIVE); end
    tick(100);
    n_checks++; if (dbg_tone_cnt !== 21'd1528804 || dbg_phase !== 1'b0) begin n_fail++; $display("FAIL oct1_count: got cnt=%0d ph=%0d want 1528804 0", dbg_tone_cnt, dbg_phase); end
  endtask

  task automatic test_tone_period_reset();
    int highs;
    int waited;
    apply_reset();
    drive(3'd7, NOTE_B);
    tick(2);
    n_checks++; if (dbg_tone_cnt !== 21'd12654 || dbg_phase !== 1'b0) begin n_fail++; $display("FAIL b7_load: got cnt=%0d ph=%0d want 12654 0", dbg_tone_cnt, dbg_phase); end
    tick(12653);
    n_checks++; if (dbg_tone_cnt !== 21'd1 || dbg_phase !== 1'b0) begin n_fail++; $display("FAIL b7_before_toggle: got cnt=%0d ph=%0d want 1 0", dbg_tone_cnt, dbg_phase); end
    tick(1);
    n_checks++; if (dbg_tone_cnt !== 21'd12654 || dbg_phase !== 1'b1) begin n_fail++; $display("FAIL b7_toggle: got cnt=%0d ph=%0d want 12654 1", dbg_tone_cnt, dbg_phase); end
    tick(1);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1);
      if (AIN === 1'b1) highs++;
    end
    n_checks++; if (highs !== 255) begin n_fail++; $display("FAIL pwm_full_duty: got %0d high cycles want 255", highs); end
    tick(89);
    drive(3'd7, NOTE_A);
    tick(12307);
    n_checks++; if (dbg_tone_cnt !== 21'd1 || dbg_phase !== 1'b1) begin n_fail++; $display("FAIL legato_old_half: got cnt=%0d ph=%0d want 1 1", dbg_tone_cnt, dbg_phase); end
    tick(1);
    n_checks++; if (dbg_tone_cnt !== 21'd14204 || dbg_phase !== 1'b0) begin n_fail++; $display("FAIL legato_new_half: got cnt=%0d ph=%0d want 14204 0", dbg_tone_cnt, dbg_phase); end
    tick(1);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1);
      if (AIN !== 1'b0) highs++;
    end
    n_checks++; if (highs !== 0) begin n_fail++; $display("FAIL pwm_low_phase: got %0d high cycles want 0", highs); end
    tick(13946);
    n_checks++; if (dbg_tone_cnt !== 21'd1 || dbg_phase !== 1'b0) begin n_fail++; $display("FAIL a7_before_toggle: got cnt=%0d ph=%0d want 1 0", dbg_tone_cnt, dbg_phase); end
    tick(1);
    n_checks++; if (dbg_tone_cnt !== 21'd14204 || dbg_phase !== 1'b1) begin n_fail++; $display("FAIL a7_toggle: got cnt=%0d ph=%0d want 14204 1", dbg_tone_cnt, dbg_phase); end
    waited = 0;
    while (AIN !== 1'b1 && waited < 8) begin
      tick(1);
      waited++;
    end
    n_checks++; if (AIN !== 1'b1) begin n_fail++; $display("FAIL ain_high_before_reset: got %0b want 1", AIN); end
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if ({AIN, ACTIVE, GAIN, NC} !== 4'b0000) begin n_fail++; $display("FAIL async_reset_outputs: got %b want 0000", {AIN, ACTIVE, GAIN, NC}); end
    n_checks++; if (dbg_state !== IDLE || dbg_volume !== 8'd0 || dbg_tone_cnt !== 21'd0) begin n_fail++; $display("FAIL async_reset_state: got st=%0d vol=%0d cnt=%0d want 0 0 0", dbg_state, dbg_volume, dbg_tone_cnt); end
    drive(3'd0, 3'd0);
    tick(2);
    #3 rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    octave   = 3'd0;
    note     = 3'd0;
    lut_oct  = 3'd0;
    lut_note = 3'd0;
    test_reset();
    test_lut();
    test_attack_legato();
    test_release_reattack();
    test_simultaneous();
    test_octave1();
    test_tone_period_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_synth.md
# tone_synth

Audio back end of the piano: consumes the `{octave, note}` pair produced by the recording/playback controller and drives the PmodAMP2 pins. It generates a square-wave tone from a half-period lookup, shapes it with a linear attack/release envelope, and emits the result as a pulse-width-modulated `AIN` bitstream. It runs on the 100 MHz board clock, downstream of the note controller.

## Interface

- `CLK_HZ`, 100_000_000: input clock rate. Documents the lookup constants only; it is not used for arithmetic.
- `ENV_STEP_CYCLES`, 39062: clock cycles per envelope step. 256 steps ≈ 100 ms.
- `PWM_BITS`, 8: width of the volume value and of the PWM carrier counter.

- `clk` in 1: 100 MHz clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `octave` in 3: octave 1..7. Value 0 means silence.
- `note` in 3: note 1..7 = C..B. Value 0 means silence.
- `AIN` out 1: PWM audio to the amplifier.
- `GAIN` out 1: amplifier gain select. Held 0 (12 dB).
- `NC` out 1: unused pin. Held 0.
- `ACTIVE` out 1: amplifier enable (shutdown_n). High while state ≠ IDLE.

## Operation

- The request is valid when `octave`≠0 and `note`≠0. Any other input combination is a silence request.
- Inputs are registered once into `req_oct`/`req_note` before use.
- **Half-period lookup** (octave 4, 100 MHz): C 191113, D 170265, E 151686, F 143172, G 127551, A 113636, B 101239.
  - For octave > 4: value `>> (octave-4)`.
  - For octave < 4: value `<< (4-octave)`.
  - Result is 21 bits unsigned. The octave-1 maximum is 1,528,904, so it never overflows.
- **Tone counter**:
  - 21-bit down-counter.
  - On reaching 1, it reloads the active half-period and toggles `phase`.
  - The active half-period changes only at a reload boundary, so there are no runt half-cycles.
  - Exception: when the state is IDLE, a new valid request loads immediately, with `phase`=0.
- **Envelope FSM** (`volume` 8-bit, changes by one step every `ENV_STEP_CYCLES` via a prescaler):
  - IDLE: volume 0, tone counter halted. Valid request → ATTACK.
  - ATTACK: volume +1 per step. Reaching 255 → SUSTAIN. Silence request → RELEASE.
  - SUSTAIN: volume 255. Silence request → RELEASE.
  - RELEASE: volume −1 per step, and the last pitch keeps sounding. Reaching 0 → IDLE. Valid request → ATTACK, starting from the current volume.
  - A new valid pitch while in ATTACK or SUSTAIN is legato: the state and volume are unchanged and only the pitch is updated at the next boundary.
  - Volume saturates at 0 and at 255; it never wraps.
  - The prescaler clears on every state transition.
- **PWM**:
  - 8-bit free-running carrier counter (≈390 kHz).
  - `AIN` = `phase & (carrier < volume)`, registered.
  - Consequence: with volume 255 the output is high for 255 of every 256 cycles during the high phase.

## Timing

- All outputs reset to 0. Reset also clears state (IDLE), volume, phase, tone counter, carrier and prescaler.
- Reset is asynchronous. Assertion mid-tone forces `AIN`/`ACTIVE` low in the same instant.
- Input to effect:
  - From IDLE: request registered at edge N, state = ATTACK and `ACTIVE`=1 at edge N+1. The first `phase` toggle occurs one half-period after that.
  - Pitch change while sounding: takes effect at the first reload at or after edge N+1.
- The first volume increment occurs `ENV_STEP_CYCLES` cycles after entering ATTACK.
- `AIN` lags the `phase`/`carrier` comparison by 1 cycle.
- Simultaneous events:
  - A silence request on the same cycle as the envelope reaches 255 in ATTACK: the result is RELEASE.
  - A valid request on the same cycle as the envelope reaches 0 in RELEASE: the result is ATTACK (volume 0), not IDLE.

## Structure

- Shared package `piano_pkg` holds:
  - note code constants `NOTE_C`..`NOTE_B`;
  - the octave-4 half-period constant array;
  - the envelope state enum (IDLE, ATTACK, SUSTAIN, RELEASE).
- One combinational sub-module, `tone_period_lut`: `(octave, note)` → 21-bit half-period, with the shift rule applied.
- Counters, FSM and PWM live in `tone_synth`.

## Test plan

All scenarios use `ENV_STEP_CYCLES`=4.

- Reset then idle inputs (0,0) → `AIN`=`ACTIVE`=`GAIN`=`NC`=0 indefinitely; release `rst_n` mid-sim and check no glitch.
- Apply (4, A) → `ACTIVE` high 1 cycle later; `phase` period measures 227272 cycles; volume reaches 255 after 1020 cycles; state SUSTAIN.
- Switch (4, A)→(5, C) while in SUSTAIN → current half-period completes at 113636; the next half-period is 95556; volume stays 255.
- Apply (7, B) then (1, C) → half-periods of 12654 and 1528904 respectively, with no counter overflow.
- In SUSTAIN apply (0, x) → RELEASE; volume reaches 0 after 1020 cycles; `ACTIVE` falls the next cycle; `AIN` stays 0 afterwards.
- Mid-RELEASE at volume 100 apply (3, E) → ATTACK resumes from 100 with half-period 303372; assert `rst_n`=0 mid-tone → all outputs 0 immediately.
